// File: rtl/rgb_pwm_arbiter.sv
// Two-LED RGB PWM driver arbitrating between a persistent software setpoint
// and a timed high-priority event flash; duty changes land only on period boundaries.
module rgb_pwm_arbiter #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned DUR_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_valid,
  output logic                  sw_ready,
  input  logic                  sw_sel,
  input  logic [3*PWM_BITS-1:0] sw_duty,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic [1:0]            ev_mask,
  input  logic [3*PWM_BITS-1:0] ev_duty,
  input  logic [DUR_BITS-1:0]   ev_dur,
  output logic                  ev_busy,
  output logic [5:0]            rgb
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef struct packed {
    logic [PWM_BITS-1:0] b;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] r;
  } duty_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACT  = 2'd2
  } ev_state_t;

  logic [PRE_W-1:0]    pre;
  logic [PWM_BITS-1:0] pc;
  logic                tick;
  logic                bound;

  duty_t               sw_shadow [2];
  duty_t               act_duty  [2];

  ev_state_t           ev_state;
  logic [1:0]          ev_mask_q;
  duty_t               ev_duty_q;
  logic [DUR_BITS-1:0] ev_dur_q;
  logic [DUR_BITS-1:0] remain;

  logic                sw_accept;
  logic                ev_accept;
  logic                ev_next_active;

  assign tick      = (pre == PRE_W'(PRESCALE - 1));
  assign bound     = tick && (pc == '1);
  assign sw_accept = sw_valid && sw_ready;
  assign ev_accept = ev_valid && ev_ready;

  // Event owns the masked LEDs during the period that starts at this boundary
  assign ev_next_active = ((ev_state == PEND) && (ev_dur_q != '0)) ||
                          ((ev_state == ACT)  && (remain != DUR_BITS'(1)));

  // Prescaler and PWM period counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      pc  <= '0;
    end else begin
      if (tick) begin
        pre <= '0;
        pc  <= pc + PWM_BITS'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  // Software write channel: always ready once out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_ready     <= 1'b0;
      sw_shadow[0] <= '0;
      sw_shadow[1] <= '0;
    end else begin
      sw_ready <= 1'b1;
      if (sw_accept) begin
        sw_shadow[sw_sel] <= duty_t'(sw_duty);
      end
    end
  end

  // Event FSM; ready/busy are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_state  <= IDLE;
      ev_ready  <= 1'b0;
      ev_busy   <= 1'b0;
      ev_mask_q <= '0;
      ev_duty_q <= '0;
      ev_dur_q  <= '0;
      remain    <= '0;
    end else begin
      case (ev_state)
        IDLE: begin
          ev_ready <= 1'b1;
          ev_busy  <= 1'b0;
          if (ev_accept) begin
            ev_mask_q <= ev_mask;
            ev_duty_q <= duty_t'(ev_duty);
            ev_dur_q  <= ev_dur;
            ev_state  <= PEND;
            ev_ready  <= 1'b0;
            ev_busy   <= 1'b1;
          end
        end
        PEND: begin
          if (bound) begin
            if (ev_dur_q == '0) begin
              ev_state <= IDLE;
              ev_ready <= 1'b1;
              ev_busy  <= 1'b0;
            end else begin
              remain   <= ev_dur_q;
              ev_state <= ACT;
            end
          end
        end
        ACT: begin
          if (bound) begin
            remain <= remain - DUR_BITS'(1);
            if (remain == DUR_BITS'(1)) begin
              ev_state <= IDLE;
              ev_ready <= 1'b1;
              ev_busy  <= 1'b0;
            end
          end
        end
        default: begin
          ev_state <= IDLE;
          ev_ready <= 1'b0;
          ev_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Active duties reload only at the period boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      act_duty[0] <= '0;
      act_duty[1] <= '0;
    end else if (bound) begin
      for (int i = 0; i < 2; i++) begin
        act_duty[i] <= (ev_next_active && ev_mask_q[i]) ? ev_duty_q : sw_shadow[i];
      end
    end
  end

  // PWM comparators; duty of all-ones leaves one low tick per period
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= '0;
    end else begin
      rgb[0] <= (pc < act_duty[0].r);
      rgb[1] <= (pc < act_duty[0].g);
      rgb[2] <= (pc < act_duty[0].b);
      rgb[3] <= (pc < act_duty[1].r);
      rgb[4] <= (pc < act_duty[1].g);
      rgb[5] <= (pc < act_duty[1].b);
    end
  end

endmodule

// File: doc/rgb_pwm_arbiter.md
# rgb_pwm_arbiter

Drives the board's six RGB LED lines (two LEDs, r/g/b each) with per-channel PWM dimming. It shares those LEDs between two requesters: a low-priority persistent software setpoint and a high-priority timed event flash, such as a status indication from the DCT datapath. It sits in the PL between the control/status logic and the `rgb[5:0]` bus that the top level breaks out to `led4_*`/`led5_*`.

## Interface
Parameters:
- `PWM_BITS`, 8: duty resolution; one PWM period is 2^PWM_BITS ticks.
- `PRESCALE`, 16: clocks per PWM tick; must be ≥ 1.
- `DUR_BITS`, 16: width of the event duration field, counted in PWM periods.

Ports:
- `clk`  in  1  — single clock domain.
- `rst`  in  1  — synchronous, active-high reset.
- `sw_valid`  in  1  — software setpoint write strobe.
- `sw_ready`  out  1  — software write accepted when high together with `sw_valid`.
- `sw_sel`  in  1  — LED select: 0 = led5 (`rgb[2:0]`), 1 = led4 (`rgb[5:3]`).
- `sw_duty`  in  3*PWM_BITS  — duty values packed as {b, g, r}; r is in the LSBs.
- `ev_valid`  in  1  — event request.
- `ev_ready`  out  1  — event accepted when high together with `ev_valid`.
- `ev_mask`  in  2  — bit0 = led5, bit1 = led4; selects which LEDs the event overrides.
- `ev_duty`  in  3*PWM_BITS  — event duty values packed as {b, g, r}.
- `ev_dur`  in  DUR_BITS  — number of full PWM periods the event is shown.
- `ev_busy`  out  1  — high while an event is pending or active.
- `rgb`  out  6  — {led4_b, led4_g, led4_r, led5_b, led5_g, led5_r}.

## Operation
- Prescaler `pre`:
  - Counts 0..PRESCALE-1 and wraps.
  - `tick` = (`pre` == PRESCALE-1).
- PWM counter `pc`:
  - Advances by 1 on `tick`, modulo 2^PWM_BITS.
  - `bound` = `tick` && (`pc` == 2^PWM_BITS-1); it marks the end of a period.
- Software setpoints:
  - Two shadow registers, one per LED, each 3*PWM_BITS wide.
  - `sw_ready` = 1 whenever the block is out of reset.
  - On an accepted write, the shadow register selected by `sw_sel` is overwritten. The last write before a boundary wins.
- Active duty registers:
  - One per LED, loaded only on `bound`. This gives glitch-free, period-aligned updates.
  - Each LED loads its event duty if it is masked by the event that is ACTIVE in the next period; otherwise it loads its software shadow.
- Event FSM:
  - IDLE:
    - `ev_ready` = 1.
    - On accept, latch mask, duty and dur, then go to PEND.
  - PEND:
    - On `bound`: if dur == 0, go to IDLE and make no visible change.
    - Otherwise, load `remain` = dur and go to ACT.
  - ACT:
    - Masked LEDs show the event duty.
    - On each `bound`, decrement `remain`. When it reaches 0, go to IDLE; the software shadows are loaded at that same bound.
  - `ev_ready` = 0 in PEND and ACT; new requests are held off (no queue).
  - `ev_busy` = (state != IDLE).
- Output:
  - `rgb[i]` is registered as (`pc` < duty_i).
  - Duty 0 gives a constant 0.
  - Duty 2^PWM_BITS-1 gives a signal high for all but one tick per period.
  - Full-on is not reachable by design.
- Simultaneous events:
  - A software write in the same cycle as `bound` is too late for that boundary; it takes effect at the next one.
  - An event accept and a software write in the same cycle are independent; both are taken.
  - A software write during ACT to a masked LED is stored and becomes visible at the first boundary after the event ends.
  - Unmasked LEDs keep following the software shadows at every boundary during an event.

## Timing
- Reset values (while `rst` is high and on the first cycle after it):
  - `rgb` = 0, `sw_ready` = 0, `ev_ready` = 0, `ev_busy` = 0.
  - `pre` = 0, `pc` = 0.
  - All shadow and active duties = 0; FSM = IDLE.
- `sw_ready` and `ev_ready` rise on the first clock after `rst` deasserts.
- Reset asserted mid-event aborts the event and clears all state on the next edge.
- Period length = PRESCALE * 2^PWM_BITS clocks.
- `rgb` lags `pc` by 1 clock.
- Software latency: from the accept edge to the new duty on `rgb`, at least 2 clocks and at most one period + 1 clock.
- Event latency: from accept to the event duty on `rgb` is the same as software latency.
- Event display: shown for exactly dur × period clocks.
- `ev_busy` falls on the same edge that reloads the software duties.

## Test plan
Run with PWM_BITS=4, PRESCALE=2 (period = 32 clk).

- **Reset/idle:** release `rst`, run 100 clk.
  - `rgb` = 0 throughout.
  - `sw_ready` = 1 and `ev_ready` = 1 from cycle 1.
- **Software duty:** write `sw_sel`=0, `sw_duty`={0, 15, 8}.
  - From the next boundary +1 clk, rgb[0] is high for 16 clk per 32.
  - rgb[1] is high for 30 clk per 32.
  - rgb[2] stays 0.
  - rgb[5:3] stays 0.
- **Event override:** with led5 software duty r=8 set, send an event with mask=2'b01, duty={15, 0, 0}, dur=3.
  - `ev_busy` is high until the event ends.
  - rgb[2] is high 30/32 for exactly 96 clk; meanwhile rgb[0] = 0.
  - Afterwards r=8 resumes.
  - A second `ev_valid` during the event sees `ev_ready` = 0.
- **Zero duration:** event with dur=0.
  - Accepted; `ev_busy` is high until the next boundary.
  - `rgb` is unchanged.
- **Boundary race:** software write in exactly the `bound` cycle.
  - The new duty appears one full period later, not at this boundary.
  - An event accept in the same cycle is also taken.
- **Reset mid-event:** assert `rst` during ACT with dur=5.
  - Next edge: `rgb` = 0, `ev_busy` = 0, duties cleared.
  - After release, no residual event color appears.
